// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with load-use hazard detection.
// A load in EX whose rd feeds a source of the valid ID instruction makes the
// slot take a bubble for one cycle. PC and IF/ID are held through Stall_o.
// Hold_i freezes everything. Flush_i discards the ID instruction.
module id_ex_hazard_reg #(
  parameter int REG_SIZE = 5,
  parameter int DATA_W   = 32,
  parameter int CNT_W    = 16
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                Hold_i,
  input  logic                Flush_i,
  input  logic                ID_valid_i,
  input  logic                ID_UsesRs1_i,
  input  logic                ID_UsesRs2_i,
  input  logic [REG_SIZE-1:0] ID_Rs1_i,
  input  logic [REG_SIZE-1:0] ID_Rs2_i,
  input  logic [REG_SIZE-1:0] ID_Rd_i,
  input  logic [DATA_W-1:0]   ID_RS1data_i,
  input  logic [DATA_W-1:0]   ID_RS2data_i,
  input  logic [DATA_W-1:0]   ID_Imm_i,
  input  logic [1:0]          ID_ALUOp_i,
  input  logic                ID_ALUSrc_i,
  input  logic [9:0]          ID_Funct_i,
  input  logic                ID_RegWrite_i,
  input  logic                ID_MemtoReg_i,
  input  logic                ID_MemRead_i,
  input  logic                ID_MemWrite_i,
  output logic                EX_valid_o,
  output logic [REG_SIZE-1:0] EX_Rs1_o,
  output logic [REG_SIZE-1:0] EX_Rs2_o,
  output logic [REG_SIZE-1:0] EX_Rd_o,
  output logic [DATA_W-1:0]   EX_RS1data_o,
  output logic [DATA_W-1:0]   EX_RS2data_o,
  output logic [DATA_W-1:0]   EX_Imm_o,
  output logic [1:0]          EX_ALUOp_o,
  output logic                EX_ALUSrc_o,
  output logic [9:0]          EX_Funct_o,
  output logic                EX_RegWrite_o,
  output logic                EX_MemtoReg_o,
  output logic                EX_MemRead_o,
  output logic                EX_MemWrite_o,
  output logic                Stall_o,
  output logic [CNT_W-1:0]    StallCount_o
);

  typedef struct packed {
    logic                valid;
    logic [REG_SIZE-1:0] rs1;
    logic [REG_SIZE-1:0] rs2;
    logic [REG_SIZE-1:0] rd;
    logic [DATA_W-1:0]   rs1_data;
    logic [DATA_W-1:0]   rs2_data;
    logic [DATA_W-1:0]   imm;
    logic [1:0]          alu_op;
    logic                alu_src;
    logic [9:0]          funct;
    logic                reg_write;
    logic                mem_to_reg;
    logic                mem_read;
    logic                mem_write;
  } ex_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  ex_t              ex_q;
  ex_t              id_slot;
  logic [CNT_W-1:0] cnt_q;
  logic             rs1_hit;
  logic             rs2_hit;
  logic             hazard;

  // Build the incoming slot. A non-valid slot keeps its fields but never
  // writes a register or memory.
  always_comb begin
    id_slot            = '0;
    id_slot.valid      = ID_valid_i;
    id_slot.rs1        = ID_Rs1_i;
    id_slot.rs2        = ID_Rs2_i;
    id_slot.rd         = ID_Rd_i;
    id_slot.rs1_data   = ID_RS1data_i;
    id_slot.rs2_data   = ID_RS2data_i;
    id_slot.imm        = ID_Imm_i;
    id_slot.alu_op     = ID_ALUOp_i;
    id_slot.alu_src    = ID_ALUSrc_i;
    id_slot.funct      = ID_Funct_i;
    id_slot.reg_write  = ID_valid_i & ID_RegWrite_i;
    id_slot.mem_to_reg = ID_valid_i & ID_MemtoReg_i;
    id_slot.mem_read   = ID_valid_i & ID_MemRead_i;
    id_slot.mem_write  = ID_valid_i & ID_MemWrite_i;
  end

  // A load-use hazard comes from the registered load in EX against the live
  // ID sources. x0 never creates a dependency.
  always_comb begin
    rs1_hit = ID_UsesRs1_i & (ex_q.rd == ID_Rs1_i);
    rs2_hit = ID_UsesRs2_i & (ex_q.rd == ID_Rs2_i);
    hazard  = ex_q.valid & ex_q.mem_read & (ex_q.rd != '0) & ID_valid_i
            & (rs1_hit | rs2_hit);
  end

  // Gate with reset so that an asserted Hold_i cannot leak a stall during reset.
  assign Stall_o = rst_n_i & (Hold_i | (hazard & ~Flush_i));

  // EX slot update: hold > flush > hazard bubble > normal load.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)     ex_q <= '0;
    else if (Hold_i)  ex_q <= ex_q;
    else if (Flush_i) ex_q <= '0;
    else if (hazard)  ex_q <= '0;
    else              ex_q <= id_slot;
  end

  // Count the bubbles inserted for load-use hazards. The count saturates.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)
      cnt_q <= '0;
    else if (!Hold_i && !Flush_i && hazard && (cnt_q != CNT_MAX))
      cnt_q <= cnt_q + 1'b1;
  end

  assign EX_valid_o    = ex_q.valid;
  assign EX_Rs1_o      = ex_q.rs1;
  assign EX_Rs2_o      = ex_q.rs2;
  assign EX_Rd_o       = ex_q.rd;
  assign EX_RS1data_o  = ex_q.rs1_data;
  assign EX_RS2data_o  = ex_q.rs2_data;
  assign EX_Imm_o      = ex_q.imm;
  assign EX_ALUOp_o    = ex_q.alu_op;
  assign EX_ALUSrc_o   = ex_q.alu_src;
  assign EX_Funct_o    = ex_q.funct;
  assign EX_RegWrite_o = ex_q.reg_write;
  assign EX_MemtoReg_o = ex_q.mem_to_reg;
  assign EX_MemRead_o  = ex_q.mem_read;
  assign EX_MemWrite_o = ex_q.mem_write;
  assign StallCount_o  = cnt_q;

endmodule

// File: doc/id_ex_hazard_reg.md
Name: id_ex_hazard_reg

Overview:
- ID/EX pipeline register with built-in load-use hazard detection for the 5-stage RISC-V pipeline.
- Captures decoded operands and control from ID, and presents EX-stage register indices (EX_Rs1_o/EX_Rs2_o) and data to the forwarding logic and ALU.
- Inserts bubbles on load-use hazards and flushes.
- Honours a global hold from later stages and counts load-use stall cycles.

Parameters:
REG_SIZE, 5, register index width
DATA_W, 32, datapath width
CNT_W, 16, stall counter width

Ports:
clk_i  input  1  clock, rising edge
rst_n_i  input  1  asynchronous active-low reset
Hold_i  input  1  freeze entire register (downstream memory stall)
Flush_i  input  1  discard ID instruction, load bubble
ID_valid_i  input  1  ID holds a real instruction
ID_UsesRs1_i  input  1  ID instruction reads rs1
ID_UsesRs2_i  input  1  ID instruction reads rs2
ID_Rs1_i  input  REG_SIZE  rs1 index
ID_Rs2_i  input  REG_SIZE  rs2 index
ID_Rd_i  input  REG_SIZE  rd index
ID_RS1data_i  input  DATA_W  rs1 read data
ID_RS2data_i  input  DATA_W  rs2 read data
ID_Imm_i  input  DATA_W  immediate
ID_ALUOp_i  input  2  ALU op class
ID_ALUSrc_i  input  1  ALU B = immediate
ID_Funct_i  input  10  funct7/funct3
ID_RegWrite_i, ID_MemtoReg_i, ID_MemRead_i, ID_MemWrite_i  input  1 each  control
EX_valid_o  output  1  EX slot holds real instruction
EX_Rs1_o, EX_Rs2_o, EX_Rd_o  output  REG_SIZE  registered indices
EX_RS1data_o, EX_RS2data_o, EX_Imm_o  output  DATA_W  registered data
EX_ALUOp_o  output  2; EX_ALUSrc_o  output  1; EX_Funct_o  output  10
EX_RegWrite_o, EX_MemtoReg_o, EX_MemRead_o, EX_MemWrite_o  output  1 each
Stall_o  output  1  hold PC and IF/ID this cycle
StallCount_o  output  CNT_W  saturating load-use bubble count

Behaviour:
- Reset (async, rst_n_i=0): every EX_* output, EX_valid_o and StallCount_o go to 0 immediately. Stall_o is 0 while in reset.
- Hazard (combinational, from registered EX state). Hazard=1 when all of the following hold:
  - EX_valid_o & EX_MemRead_o
  - EX_Rd_o != 0
  - ID_valid_i
  - (ID_UsesRs1_i & EX_Rd_o==ID_Rs1_i) | (ID_UsesRs2_i & EX_Rd_o==ID_Rs2_i)
- Stall_o = Hold_i | (Hazard & ~Flush_i); purely combinational, no latency.
- Per rising edge, priority order:
  1. Hold_i=1: all registers keep their values, counter unchanged.
  2. Flush_i=1: load bubble, counter unchanged.
  3. Hazard=1: load bubble, StallCount_o += 1, saturating at all-ones.
  4. Otherwise: load all ID_* fields; EX_valid_o <= ID_valid_i.
- Bubble: EX_valid_o, all control bits, EX_ALUOp_o, EX_ALUSrc_o, EX_Funct_o, all indices and data fields <= 0.
- An ID slot with ID_valid_i=0 is loaded as-is with EX_valid_o=0, but its control bits are forced to 0. A non-valid slot never writes a register or memory.
- Load-use latency: exactly one bubble per hazard. The next cycle EX_MemRead_o=0, so Hazard clears and the held ID instruction loads. From then on the forwarding logic covers the dependency from MEM/WB.
- Back-to-back loads each with a dependent consumer produce one bubble each, and the counter increments once per bubble.
- Hold_i asserted during a pending hazard: no bubble and no count until Hold_i drops; Hazard is then re-evaluated.
- Reset mid-stall: all state clears and Stall_o drops on the same edge that reset asserts.

Test Plan:
- Reset: drive random ID inputs, pulse rst_n_i low mid-cycle -> all EX_* outputs, EX_valid_o and StallCount_o read 0 asynchronously; Stall_o=0.
- Normal load: ID_Rs1=5, ID_Rs2=6, ID_Rd=7, RS1data=0x11, RegWrite=1, valid=1 -> next edge EX_Rs1_o=5, EX_Rd_o=7, EX_RS1data_o=0x11, EX_RegWrite_o=1, EX_valid_o=1, Stall_o=0.
- Load-use: EX holds lw with Rd=3; ID holds add rs1=3 with UsesRs1=1 -> Stall_o=1 that cycle; next edge bubble (EX_valid_o=0, EX_RegWrite_o=0), StallCount_o=1; following edge the add loads with EX_Rs1_o=3.
- No false hazard in each of these cases -> Stall_o=0, no bubble:
  - lw with Rd=0 and consumer rs1=0
  - lw Rd=4 with consumer rs2=4 but UsesRs2=0
  - non-load producer Rd=4
- Flush vs hazard: load-use condition present plus Flush_i=1 -> Stall_o=0, bubble loaded, StallCount_o unchanged.
- Hold: Hold_i=1 for 3 cycles with changing ID inputs and a pending hazard -> EX outputs frozen, Stall_o=1, counter frozen; after release one bubble, counter +1. Separately, preload the counter to 0xFFFF and trigger a hazard -> stays 0xFFFF.
